// File: rtl/power_lane_eval_pipe.sv
// Evaluates f = (b ^ (a & d)) & (a | c) per lane; counts output bit toggles.
// Latency: PIPE cycles from input transfer to out_valid; 1 word/cycle throughput.
// Backpressure: valid/ready, no skid; in_ready falls combinationally when full and out_ready=0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_a..in_d are LANES-bit operands
//   iso_en                1 = data registers load only when a valid word moves in
//   out_valid/out_ready   output handshake; out_f is the registered per-lane result
//   tog_clr, tog_cnt      clear / saturating count of out_f toggles between accepted words
module power_lane_eval_pipe #(
   parameter int LANES = 8,
   parameter int PIPE  = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LANES-1:0] in_a,
   input  logic [LANES-1:0] in_b,
   input  logic [LANES-1:0] in_c,
   input  logic [LANES-1:0] in_d,
   input  logic             iso_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] out_f,
   input  logic             tog_clr,
   output logic [CNT_W-1:0] tog_cnt
);

   // Popcount width and a sum width that cannot overflow before saturation.
   localparam int PCW = $clog2(LANES + 1);
   localparam int SW  = CNT_W + PCW;

   logic [PIPE-1:0]  r_v;
   logic [LANES-1:0] r_data [PIPE];
   logic [LANES-1:0] r_last;
   logic [CNT_W-1:0] r_cnt;

   logic [LANES-1:0] w_f;
   logic [PIPE-1:0]  w_adv;
   logic             w_run;
   logic             w_acc;
   logic [LANES-1:0] w_x;
   logic [PCW-1:0]   w_pop;
   logic [SW-1:0]    w_sum;
   logic [CNT_W-1:0] w_max;

   assign w_f = (in_b ^ (in_a & in_d)) & (in_a | in_c);

   // Stage k advances when out_ready is high or any stage at or after k is empty.
   always_comb begin
      w_adv = '0;
      w_run = out_ready;
      for (int k = PIPE - 1; k >= 0; k--) begin
         w_run    = w_run | ~r_v[k];
         w_adv[k] = w_run;
      end
   end

   assign w_acc = r_v[PIPE-1] & out_ready;
   assign w_x   = r_data[PIPE-1] ^ r_last;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         w_pop = w_pop + PCW'(w_x[i]);
      end
   end

   assign w_sum = SW'(r_cnt) + SW'(w_pop);
   assign w_max = {CNT_W{1'b1}};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v    <= '0;
         r_last <= '0;
         r_cnt  <= '0;
         for (int k = 0; k < PIPE; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         if (w_adv[0]) begin
            r_v[0] <= in_valid;
            if (!iso_en || in_valid) begin
               r_data[0] <= w_f;
            end
         end
         for (int k = 1; k < PIPE; k++) begin
            if (w_adv[k]) begin
               r_v[k] <= r_v[k-1];
               // With isolation on, bubbles leave the stage data untouched.
               if (!iso_en || r_v[k-1]) begin
                  r_data[k] <= r_data[k-1];
               end
            end
         end
         if (w_acc) begin
            r_last <= r_data[PIPE-1];
         end
         // Clear wins over the same-cycle increment; last value still tracks the accept.
         if (tog_clr) begin
            r_cnt <= '0;
         end else if (w_acc) begin
            r_cnt <= (w_sum > SW'(w_max)) ? w_max : w_sum[CNT_W-1:0];
         end
      end
   end

   assign in_ready  = w_adv[0];
   assign out_valid = r_v[PIPE-1];
   assign out_f     = r_data[PIPE-1];
   assign tog_cnt   = r_cnt;

endmodule
